vx_alu_route_arb: RTL and testbench
===================================

VX_ALU_ROUTE_ARB -- requirements
Module: VX_alu_route_arb

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 3: number of execution sub-units, legal range 1..8.
REQ-002 SHALL have parameter REQ_DATAW, default 64: request payload width in bits.
REQ-003 SHALL have parameter RSP_DATAW, default 64: response payload width in bits.
REQ-004 SHALL have parameter MAX_PENDING, default 4: per-unit outstanding-request limit, legal range 1..255.
REQ-005 SHALL derive SEL_BITS = max(1, clog2(NUM_UNITS)) and CNT_BITS = clog2(MAX_PENDING+1).
REQ-006 Ports SHALL be as follows.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  upstream request valid.
- req_sel  input  SEL_BITS  target sub-unit index.
- req_data  input  REQ_DATAW  request payload.
- req_ready  output  1  request accepted this cycle.
- unit_req_valid  output  NUM_UNITS  per-unit request valid, at most one bit set.
- unit_req_data  output  REQ_DATAW  payload broadcast to all units.
- unit_req_ready  input  NUM_UNITS  per-unit request ready.
- unit_rsp_valid  input  NUM_UNITS  per-unit response valid.
- unit_rsp_data  input  NUM_UNITS*RSP_DATAW  responses; unit i occupies slice [i*RSP_DATAW +: RSP_DATAW].
- unit_rsp_ready  output  NUM_UNITS  per-unit response ready.
- rsp_valid  output  1  merged response valid (registered).
- rsp_data  output  RSP_DATAW  merged response payload (registered).
- rsp_sel  output  SEL_BITS  index of the unit that produced rsp_data (registered).
- rsp_ready  input  1  downstream ready.
- busy  output  1  any request outstanding or output register occupied.
- sel_err  output  1  one-cycle registered pulse when an out-of-range request is dropped.

Function
REQ-007 SHALL route requests combinationally: unit_req_valid[i] = req_valid && req_sel==i && cnt[i]<MAX_PENDING; unit_req_data = req_data.
REQ-008 SHALL drive req_ready = unit_req_ready[req_sel] && cnt[req_sel]<MAX_PENDING when req_sel<NUM_UNITS.
REQ-009 When req_sel>=NUM_UNITS, SHALL assert req_ready, assert no unit_req_valid bit, discard the request, and pulse sel_err on the next cycle.
REQ-010 SHALL keep a per-unit counter cnt[i]: +1 on a unit i issue fire (unit_req_valid[i] && unit_req_ready[i]); -1 on a unit i response fire (unit_rsp_valid[i] && unit_rsp_ready[i]); unchanged when both fire in the same cycle.
REQ-011 At cnt[i]==MAX_PENDING, SHALL hold req_ready low for unit i; a same-cycle response fire SHALL NOT unblock the request in that cycle.
REQ-012 A response arriving while cnt[i]==0 is a protocol error: the counter SHALL saturate at 0 and the response SHALL still be forwarded.
REQ-013 SHALL arbitrate valid unit responses round-robin, starting the search at pointer rr and granting the first valid index at or after rr.
REQ-014 After a response grant fires to unit g, SHALL update rr to (g+1) mod NUM_UNITS; with no fire, rr SHALL hold.
REQ-015 SHALL define the load condition as (!rsp_valid || rsp_ready) and drive unit_rsp_ready[i] = grant[i] && load condition.
REQ-016 When a response grant fires, SHALL load rsp_data, rsp_sel and rsp_valid=1 on the next edge, giving 1-cycle latency.
REQ-017 When the load condition holds and no grant fires, SHALL clear rsp_valid.
REQ-018 While rsp_valid && !rsp_ready, SHALL hold rsp_valid, rsp_data and rsp_sel stable.
REQ-019 SHALL sustain one response per cycle when rsp_ready stays high.
REQ-020 SHALL drive busy = (any cnt[i]!=0) || rsp_valid.
REQ-021 For NUM_UNITS==1, SHALL behave as a credit-limited pass-through with rr constant 0.

Reset
REQ-022 On reset, SHALL clear every cnt[i], rr, rsp_valid and sel_err to 0; rsp_data and rsp_sel are don't-care.
REQ-023 Reset SHALL override all same-cycle fires; in-flight requests are forgotten, and unit-side reset is the integrator's responsibility.
REQ-024 Combinational outputs SHALL reflect the cleared state in the first cycle after reset: busy=0, rsp_valid=0.

Verification
REQ-025 Configure NUM_UNITS=3, MAX_PENDING=2, unit 1 always ready, no responses; send 3 requests with sel=1 -> first two accepted, third stalled with req_ready=0, cnt[1]=2, busy=1.
REQ-026 Continue from REQ-025 with the stall held, then raise unit_rsp_valid[1] -> response fires, rsp_valid=1 one cycle later with rsp_sel=1; the stalled request is accepted the following cycle.
REQ-027 Hold all three unit_rsp_valid high with rsp_ready=1 -> rsp_sel sequence is 0,1,2,0,1,2, one response per cycle.
REQ-028 Set rsp_ready=0 for 4 cycles with units 0 and 2 valid -> rsp_data and rsp_sel frozen and unit_rsp_ready all 0; on release, responses drain in round-robin order.
REQ-029 Send req_sel=3 with NUM_UNITS=3 -> req_ready=1, no unit_req_valid bit set, sel_err=1 for exactly one cycle, all counters unchanged.
REQ-030 Assert reset with cnt[0]=2 and rsp_valid=1 -> the next cycle shows cnt=0, rsp_valid=0, busy=0 and rr=0.

Source files
------------

// File: rtl/vx_alu_route_arb.sv
// Routes requests to one of NUM_UNITS execution sub-units under per-unit credit
// limits, and merges their responses round-robin into one registered output.
module vx_alu_route_arb #(
  parameter int NUM_UNITS   = 3,
  parameter int REQ_DATAW   = 64,
  parameter int RSP_DATAW   = 64,
  parameter int MAX_PENDING = 4,
  localparam int SEL_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CNT_BITS   = $clog2(MAX_PENDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [SEL_BITS-1:0]            req_sel,
  input  logic [REQ_DATAW-1:0]           req_data,
  output logic                           req_ready,
  output logic [NUM_UNITS-1:0]           unit_req_valid,
  output logic [REQ_DATAW-1:0]           unit_req_data,
  input  logic [NUM_UNITS-1:0]           unit_req_ready,
  input  logic [NUM_UNITS-1:0]           unit_rsp_valid,
  input  logic [NUM_UNITS*RSP_DATAW-1:0] unit_rsp_data,
  output logic [NUM_UNITS-1:0]           unit_rsp_ready,
  output logic                           rsp_valid,
  output logic [RSP_DATAW-1:0]           rsp_data,
  output logic [SEL_BITS-1:0]            rsp_sel,
  input  logic                           rsp_ready,
  output logic                           busy,
  output logic                           sel_err
);

  localparam logic [SEL_BITS:0]   NUM_U = (SEL_BITS+1)'(NUM_UNITS);
  localparam logic [CNT_BITS-1:0] MAX_P = CNT_BITS'(MAX_PENDING);

  logic [CNT_BITS-1:0]  cnt_q [NUM_UNITS];
  logic [CNT_BITS-1:0]  cnt_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] room_s;
  logic [NUM_UNITS-1:0] cnt_nz_s;
  logic                 sel_ok_s;
  logic [SEL_BITS-1:0]  rr_q, rr_d;
  logic [SEL_BITS:0]    idx_s;
  logic [SEL_BITS:0]    nxt_s;
  logic [NUM_UNITS-1:0] grant_s;
  logic [SEL_BITS-1:0]  grant_idx_s;
  logic                 grant_any_s;
  logic [RSP_DATAW-1:0] grant_data_s;
  logic                 load_s;
  logic                 rsp_fire_s;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [RSP_DATAW-1:0] rsp_data_q, rsp_data_d;
  logic [SEL_BITS-1:0]  rsp_sel_q, rsp_sel_d;
  logic                 sel_err_q, sel_err_d;

  assign unit_req_data = req_data;

  // Request steering; an out-of-range select is swallowed with req_ready high.
  always_comb begin
    sel_ok_s       = ({1'b0, req_sel} < NUM_U);
    req_ready      = 1'b1;
    unit_req_valid = '0;
    room_s         = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      room_s[i] = (cnt_q[i] < MAX_P);
      if (sel_ok_s && (req_sel == SEL_BITS'(i))) begin
        unit_req_valid[i] = req_valid && room_s[i];
        req_ready         = unit_req_ready[i] && room_s[i];
      end else begin
        unit_req_valid[i] = 1'b0;
      end
    end
  end

  // Round-robin search starting at rr_q; first valid index wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    idx_s       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx_s = {1'b0, rr_q} + (SEL_BITS+1)'(k);
      if (idx_s >= NUM_U) begin
        idx_s = idx_s - NUM_U;
      end else begin
        idx_s = idx_s;
      end
      if (!grant_any_s && unit_rsp_valid[idx_s[SEL_BITS-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = idx_s[SEL_BITS-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot grant, granted payload mux and the response handshake.
  always_comb begin
    grant_s      = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      grant_s[i] = grant_any_s && (grant_idx_s == SEL_BITS'(i));
      if (grant_s[i]) begin
        grant_data_s = unit_rsp_data[i*RSP_DATAW +: RSP_DATAW];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
    load_s         = !rsp_valid_q || rsp_ready;
    unit_rsp_ready = grant_s & {NUM_UNITS{load_s}};
    rsp_fire_s     = grant_any_s && load_s;
  end

  // Per-unit outstanding counters; a stray response at zero saturates.
  always_comb begin
    cnt_nz_s = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cnt_nz_s[i] = (cnt_q[i] != '0);
      case ({unit_req_valid[i] && unit_req_ready[i], unit_rsp_valid[i] && unit_rsp_ready[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
        2'b01:   cnt_d[i] = cnt_nz_s[i] ? (cnt_q[i] - CNT_BITS'(1)) : '0;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Output register, round-robin pointer and select-error next state.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    rr_d        = rr_q;
    nxt_s       = {1'b0, grant_idx_s} + (SEL_BITS+1)'(1);
    if (rsp_fire_s) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = grant_data_s;
      rsp_sel_d   = grant_idx_s;
      rr_d        = (nxt_s >= NUM_U) ? '0 : nxt_s[SEL_BITS-1:0];
    end else if (load_s) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    sel_err_d = req_valid && !sel_ok_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cnt_q[i] <= '0;
      end
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;
  assign sel_err   = sel_err_q;
  assign busy      = rsp_valid_q || (|cnt_nz_s);

endmodule

// File: tb/tb_vx_alu_route_arb.sv
// Bench for vx_alu_route_arb: routing vector table, credit stall, round-robin
// merge, back-pressure freeze, select error and reset, with a response scoreboard.
module tb_vx_alu_route_arb;

  localparam int N  = 3;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [1:0]    req_sel;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic [N-1:0]  unit_req_valid;
  logic [DW-1:0] unit_req_data;
  logic [N-1:0]  unit_req_ready;
  logic [N-1:0]  unit_rsp_valid;
  logic [N*DW-1:0] unit_rsp_data;
  logic [N-1:0]  unit_rsp_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_sel;
  logic          rsp_ready;
  logic          busy;
  logic          sel_err;

  vx_alu_route_arb #(.NUM_UNITS(N), .REQ_DATAW(DW), .RSP_DATAW(DW), .MAX_PENDING(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
    .unit_req_valid(unit_req_valid), .unit_req_data(unit_req_data), .unit_req_ready(unit_req_ready),
    .unit_rsp_valid(unit_rsp_valid), .unit_rsp_data(unit_rsp_data), .unit_rsp_ready(unit_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_ready(rsp_ready),
    .busy(busy), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] sel; logic [DW-1:0] data; } rsp_t;
  typedef struct {
    logic v; logic [1:0] sel; logic [2:0] urr; logic [DW-1:0] data;
    logic exp_rdy; logic [2:0] exp_uv; logic exp_busy; logic exp_err;
  } vec_t;

  rsp_t exp_q[$];
  vec_t vecs [7];
  logic [DW-1:0] dtab [3];
  int n_total = 0;
  int n_pass  = 0;

  localparam logic [DW-1:0] D0  = 16'h1A00;
  localparam logic [DW-1:0] D1  = 16'h1B11;
  localparam logic [DW-1:0] D2  = 16'h1C22;
  localparam logic [DW-1:0] D0B = 16'h2A55;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [1:0] sel, input logic [DW-1:0] data);
    rsp_t e;
    e.sel  = sel;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; unit_rsp_valid = 3'b000; rsp_ready = 1'b1;
    unit_rsp_data = {D2, D1, D0};
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: compare every response the downstream side accepts.
  always @(negedge clk) begin
    rsp_t e;
    #2;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_sel", 64'(rsp_sel), 64'(e.sel));
        check("sb_rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  initial begin
    dtab[0] = D0; dtab[1] = D1; dtab[2] = D2;
    vecs[0] = '{1'b1, 2'd0, 3'b001, 16'h0101, 1'b1, 3'b001, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 3'b001, 16'h0202, 1'b0, 3'b010, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 3'b100, 16'h0303, 1'b1, 3'b100, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'd1, 3'b111, 16'h0404, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'd3, 3'b111, 16'h0505, 1'b1, 3'b000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'd3, 3'b000, 16'h0606, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd2, 3'b011, 16'h0707, 1'b0, 3'b100, 1'b0, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_data = 16'h0000;
    unit_req_ready = 3'b000; unit_rsp_valid = 3'b000; rsp_ready = 1'b1;
    unit_rsp_data = {D2, D1, D0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    check("rst_unit_req_valid", 64'(unit_req_valid), 64'd0);
    check("rst_unit_rsp_ready", 64'(unit_rsp_ready), 64'd0);

    // Routing table, each row from a cleared state.
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      req_valid = vecs[r].v; req_sel = vecs[r].sel; unit_req_ready = vecs[r].urr;
      req_data = vecs[r].data;
      #1;
      check("vec_req_ready", 64'(req_ready), 64'(vecs[r].exp_rdy));
      check("vec_unit_req_valid", 64'(unit_req_valid), 64'(vecs[r].exp_uv));
      check("vec_unit_req_data", 64'(unit_req_data), 64'(vecs[r].data));
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("vec_busy_next", 64'(busy), 64'(vecs[r].exp_busy));
      check("vec_sel_err_next", 64'(sel_err), 64'(vecs[r].exp_err));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    // Credit limit on unit 1, then a response frees one slot.
    @(negedge clk);
    unit_req_ready = 3'b111; req_valid = 1'b1; req_sel = 2'd1; req_data = 16'hBEEF;
    #1 check("cr_accept1", 64'(req_ready), 64'd1);
    @(negedge clk); #1;
    check("cr_accept2", 64'(req_ready), 64'd1);
    check("cr_busy", 64'(busy), 64'd1);
    @(negedge clk); #1;
    check("cr_stall", 64'(req_ready), 64'd0);
    check("cr_stall_uv", 64'(unit_req_valid), 64'd0);
    check("cr_stall_busy", 64'(busy), 64'd1);
    @(negedge clk);
    unit_rsp_valid = 3'b010;
    push_exp(2'd1, D1);
    #1;
    check("cr_same_cycle_stall", 64'(req_ready), 64'd0);
    check("cr_unit_rsp_ready", 64'(unit_rsp_ready), 64'd2);
    @(negedge clk);
    unit_rsp_valid = 3'b000;
    #1;
    check("cr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("cr_rsp_sel", 64'(rsp_sel), 64'd1);
    check("cr_unblocked", 64'(req_ready), 64'd1);
    check("cr_unblocked_uv", 64'(unit_req_valid), 64'd2);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("cr_rsp_cleared", 64'(rsp_valid), 64'd0);
    check("cr_full_again", 64'(req_ready), 64'd0);
    check("cr_busy_after", 64'(busy), 64'd1);
    reset_dut();

    // All units valid: strict 0,1,2 rotation at one response per cycle.
    @(negedge clk);
    unit_rsp_valid = 3'b111;
    for (int k = 0; k < 6; k++) push_exp(2'(k % 3), dtab[k % 3]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("rr_valid_each_cycle", 64'(rsp_valid), 64'd1);
      check("rr_sel_order", 64'(rsp_sel), 64'(k % 3));
    end
    unit_rsp_valid = 3'b000;
    @(negedge clk); #1;
    check("rr_drained", 64'(rsp_valid), 64'd0);
    check("rr_saturated_busy", 64'(busy), 64'd0);
    check("rr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure: output frozen for 4 cycles while units 0 and 2 wait.
    @(negedge clk);
    unit_rsp_valid = 3'b101;
    push_exp(2'd0, D0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) rsp_ready = 1'b0;
      if (k == 1) unit_rsp_data = {D2, D1, D0B};
      #1;
      check("bp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_sel_held", 64'(rsp_sel), 64'd0);
      check("bp_data_held", 64'(rsp_data), 64'(D0));
      check("bp_no_unit_ready", 64'(unit_rsp_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    push_exp(2'd2, D2);
    push_exp(2'd0, D0B);
    #1 check("bp_release_grant2", 64'(unit_rsp_ready), 64'd4);
    @(negedge clk); #1;
    check("bp_next_grant0", 64'(unit_rsp_ready), 64'd1);
    @(negedge clk);
    unit_rsp_valid = 3'b000;
    @(negedge clk); #1;
    check("bp_drained", 64'(rsp_valid), 64'd0);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    reset_dut();

    // Out-of-range select: dropped, one-cycle error, counters untouched.
    @(negedge clk);
    req_valid = 1'b1; req_sel = 2'd0; unit_req_ready = 3'b111;
    #1 check("se_pre_accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_sel = 2'd3;
    #1;
    check("se_ready", 64'(req_ready), 64'd1);
    check("se_no_unit_valid", 64'(unit_req_valid), 64'd0);
    check("se_err_before", 64'(sel_err), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("se_err_pulse", 64'(sel_err), 64'd1);
    check("se_busy", 64'(busy), 64'd1);
    @(negedge clk); #1;
    check("se_err_one_cycle", 64'(sel_err), 64'd0);
    @(negedge clk);
    req_valid = 1'b1; req_sel = 2'd0;
    #1 check("se_cnt0_one_slot", 64'(req_ready), 64'd1);
    @(negedge clk); #1;
    check("se_cnt0_full", 64'(req_ready), 64'd0);

    // Reset with cnt[0]=2, rsp_valid=1 and rr moved off zero.
    @(negedge clk);
    req_valid = 1'b0; unit_rsp_valid = 3'b010; rsp_ready = 1'b1;
    @(negedge clk);
    unit_rsp_valid = 3'b000; rsp_ready = 1'b0;
    #1;
    check("rs_pre_valid", 64'(rsp_valid), 64'd1);
    check("rs_pre_sel", 64'(rsp_sel), 64'd1);
    check("rs_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rs_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_sel_err", 64'(sel_err), 64'd0);
    check("rs_cnt0_free", 64'(req_ready), 64'd1);
    @(negedge clk);
    unit_rsp_valid = 3'b101; rsp_ready = 1'b1;
    push_exp(2'd0, D0);
    #1 check("rs_rr_zero", 64'(unit_rsp_ready), 64'd1);
    @(negedge clk);
    unit_rsp_valid = 3'b000;
    @(negedge clk); #1;
    check("rs_drained", 64'(rsp_valid), 64'd0);
    check("rs_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
